// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage with PC select, req/ack imem fetch, stall hold buffer and IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00400030,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    pc_sel,
  input  logic [AW-1:0] branch_target,
  input  logic [AW-1:0] jump_target,
  input  logic [AW-1:0] jr_target,
  input  logic          stall,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   if_id_instr,
  output logic [AW-1:0] if_id_pc4,
  output logic          if_id_valid,
  output logic [AW-1:0] pc_out
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [31:0]   r_hold_instr;
  logic [AW-1:0] r_hold_pc4;
  logic [AW-1:0] w_pc4;
  logic [AW-1:0] w_target;
  assign w_pc4     = r_pc + AW'(4);
  assign w_target  = (pc_sel == 2'd1) ? {branch_target[AW-1:2], 2'b00} :
                     (pc_sel == 2'd2) ? {jump_target[AW-1:2], 2'b00} :
                                        {jr_target[AW-1:2], 2'b00};
  assign imem_req  = !reset && (r_state == FETCH);
  assign imem_addr = r_pc;
  assign pc_out    = r_pc;
  // PC, FSM, hold buffer and IF/ID; redirect beats stall and ack, dropping any same-cycle ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC[AW-1:0];
      r_hold_instr <= '0;
      r_hold_pc4   <= '0;
      if_id_instr  <= '0;
      if_id_pc4    <= '0;
      if_id_valid  <= 1'b0;
    end else if (pc_sel != 2'd0) begin
      r_pc        <= w_target;
      if_id_valid <= 1'b0;
      r_state     <= FETCH;
    end else if (r_state == FETCH) begin
      if (imem_ack && !stall) begin
        if_id_instr <= imem_rdata;
        if_id_pc4   <= w_pc4;
        if_id_valid <= 1'b1;
        r_pc        <= w_pc4;
      end else if (imem_ack) begin
        r_hold_instr <= imem_rdata;
        r_hold_pc4   <= w_pc4;
        r_state      <= HOLD;
      end else if (!stall) begin
        if_id_valid <= 1'b0;
      end
    end else if (!stall) begin
      if_id_instr <= r_hold_instr;
      if_id_pc4   <= r_hold_pc4;
      if_id_valid <= 1'b1;
      r_pc        <= w_pc4;
      r_state     <= FETCH;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven directed check of fetch_stage
module tb_fetch_stage;
  logic        clk, reset, stall, imem_req, imem_ack, if_id_valid;
  logic [1:0]  pc_sel;
  logic [31:0] branch_target, jump_target, jr_target, imem_addr, imem_rdata;
  logic [31:0] if_id_instr, if_id_pc4, pc_out;
  int checks = 0, errors = 0;
  typedef struct {
    logic        rst;
    logic [1:0]  sel;
    logic        stall;
    logic        ack;
    logic [31:0] rd;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
  } vec_t;
  vec_t q[$];
  fetch_stage dut (
    .clk(clk), .reset(reset), .pc_sel(pc_sel), .branch_target(branch_target),
    .jump_target(jump_target), .jr_target(jr_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .pc_out(pc_out)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic vec_t mk(logic rst, logic [1:0] sel, logic st, logic ack, logic [31:0] rd,
                              logic [31:0] tgt, logic e_req, logic [31:0] e_addr, logic e_valid,
                              logic [31:0] e_pc4, logic [31:0] e_instr);
    vec_t v;
    v = '{rst, sel, st, ack, rd, tgt, e_req, e_addr, e_valid, e_pc4, e_instr};
    return v;
  endfunction
  task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask
  initial begin
    reset = 1; pc_sel = 0; stall = 0; imem_ack = 0; imem_rdata = 0;
    branch_target = 0; jump_target = 0; jr_target = 0;
    //        rst sel st ack rd            tgt           req addr          v  pc4           instr
    q.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h00400030, 0, 32'h0,        32'h0));
    q.push_back(mk(0, 0, 0, 1, 32'hAA000030, 32'h0,        1, 32'h00400030, 0, 32'h0,        32'h0));
    q.push_back(mk(0, 0, 0, 1, 32'hAA000034, 32'h0,        1, 32'h00400034, 1, 32'h00400034, 32'hAA000030));
    q.push_back(mk(0, 0, 0, 1, 32'hAA000038, 32'h0,        1, 32'h00400038, 1, 32'h00400038, 32'hAA000034));
    q.push_back(mk(0, 0, 0, 1, 32'hAA00003C, 32'h0,        1, 32'h0040003C, 1, 32'h0040003C, 32'hAA000038));
    q.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h00400040, 1, 32'h00400040, 32'hAA00003C));
    q.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h00400030, 0, 32'h0,        32'h0));
    q.push_back(mk(0, 0, 0, 1, 32'hAA000030, 32'h0,        1, 32'h00400030, 0, 32'h0,        32'h0));
    q.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h00400034, 1, 32'h00400034, 32'hAA000030));
    q.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h00400034, 0, 32'h00400034, 32'hAA000030));
    q.push_back(mk(0, 0, 0, 1, 32'hAA000034, 32'h0,        1, 32'h00400034, 0, 32'h00400034, 32'hAA000030));
    q.push_back(mk(0, 0, 1, 1, 32'hAA000038, 32'h0,        1, 32'h00400038, 1, 32'h00400038, 32'hAA000034));
    q.push_back(mk(0, 0, 1, 0, 32'h0,        32'h0,        0, 32'h00400038, 1, 32'h00400038, 32'hAA000034));
    q.push_back(mk(0, 0, 1, 1, 32'hBAD00000, 32'h0,        0, 32'h00400038, 1, 32'h00400038, 32'hAA000034));
    q.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h00400038, 1, 32'h00400038, 32'hAA000034));
    q.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h0040003C, 1, 32'h0040003C, 32'hAA000038));
    q.push_back(mk(0, 1, 1, 1, 32'hDEADBEEF, 32'h00400103, 1, 32'h0040003C, 0, 32'h0040003C, 32'hAA000038));
    q.push_back(mk(0, 0, 0, 1, 32'hAB000100, 32'h0,        1, 32'h00400100, 0, 32'h0040003C, 32'hAA000038));
    q.push_back(mk(0, 3, 0, 0, 32'h0,        32'hFFFFFFFC, 1, 32'h00400104, 1, 32'h00400104, 32'hAB000100));
    q.push_back(mk(0, 0, 0, 1, 32'hAA0000FC, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h00400104, 32'hAB000100));
    q.push_back(mk(0, 0, 0, 1, 32'hAA000000, 32'h0,        1, 32'h00000000, 1, 32'h00000000, 32'hAA0000FC));
    q.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h00000004, 1, 32'h00000004, 32'hAA000000));
    q.push_back(mk(0, 0, 1, 1, 32'hBB000004, 32'h0,        1, 32'h00000004, 0, 32'h00000004, 32'hAA000000));
    q.push_back(mk(0, 2, 1, 0, 32'h0,        32'h00400201, 0, 32'h00000004, 0, 32'h00000004, 32'hAA000000));
    q.push_back(mk(0, 0, 0, 1, 32'hCC000200, 32'h0,        1, 32'h00400200, 0, 32'h00000004, 32'hAA000000));
    q.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h00400204, 1, 32'h00400204, 32'hCC000200));
    q.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h00400204, 0, 32'h00400204, 32'hCC000200));
    q.push_back(mk(1, 0, 0, 1, 32'hEEEEEEEE, 32'h0,        0, 32'h00400030, 0, 32'h0,        32'h0));
    q.push_back(mk(1, 0, 0, 1, 32'hEEEEEEEE, 32'h0,        0, 32'h00400030, 0, 32'h0,        32'h0));
    q.push_back(mk(0, 0, 0, 1, 32'hAA000030, 32'h0,        1, 32'h00400030, 0, 32'h0,        32'h0));
    q.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h00400034, 1, 32'h00400034, 32'hAA000030));
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      reset = q[i].rst; pc_sel = q[i].sel; stall = q[i].stall;
      imem_ack = q[i].ack; imem_rdata = q[i].rd;
      branch_target = (q[i].sel == 2'd1) ? q[i].tgt : 32'h11111110;
      jump_target   = (q[i].sel == 2'd2) ? q[i].tgt : 32'h22222220;
      jr_target     = (q[i].sel == 2'd3) ? q[i].tgt : 32'h33333330;
      #1;
      chk(i, "imem_req", {31'b0, imem_req}, {31'b0, q[i].e_req});
      chk(i, "imem_addr", imem_addr, q[i].e_addr);
      chk(i, "pc_out", pc_out, q[i].e_addr);
      chk(i, "if_id_valid", {31'b0, if_id_valid}, {31'b0, q[i].e_valid});
      chk(i, "if_id_pc4", if_id_pc4, q[i].e_pc4);
      chk(i, "if_id_instr", if_id_instr, q[i].e_instr);
    end
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk(99, "async_rst_valid", {31'b0, if_id_valid}, 32'h0);
    chk(99, "async_rst_pc", pc_out, 32'h00400030);
    chk(99, "async_rst_req", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    reset = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
